// File: rtl/sha_loader_pkg.sv
// Shared constants and state encoding for the SHA block loader.
// Imported by block_loader_160_if, block_loader_160 and the testbench.
package sha_loader_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 5;
  localparam int BLOCK_W   = WORD_W * NUM_WORDS;
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } load_state_t;

endpackage

// File: rtl/block_loader_160_if.sv
// Word bus, core handshake and block memory write port of the block loader.
// master = host / downstream side, slave = the loader itself.
interface block_loader_160_if;
  import sha_loader_pkg::*;

  logic               flush;
  logic               word_valid;
  logic [WORD_W-1:0]  word_in;
  logic               word_ready;
  logic               core_busy;
  logic               write_en;
  logic [BLOCK_W-1:0] block_out;
  logic [CNT_W-1:0]   word_count;
  logic               block_done;

  modport master (
    output flush,
    output word_valid,
    output word_in,
    output core_busy,
    input  word_ready,
    input  write_en,
    input  block_out,
    input  word_count,
    input  block_done
  );

  modport slave (
    input  flush,
    input  word_valid,
    input  word_in,
    input  core_busy,
    output word_ready,
    output write_en,
    output block_out,
    output word_count,
    output block_done
  );

endinterface

// File: rtl/word_byte_swap32.sv
// Combinational byte reversal of a 32-bit word (little-endian header fields).
module word_byte_swap32 (
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign word_out[8*gi +: 8] = word_in[8*(3-gi) +: 8];
  end

endmodule

// File: rtl/block_loader_160.sv
// Collects NUM_WORDS words MSB-first into a 160-bit block and strobes it into
// block memory once the SHA core is idle. Option: BLOCK_LOADER_BYTE_SWAP_EN.
module block_loader_160 #(
  parameter int WORD_W    = sha_loader_pkg::WORD_W,
  parameter int NUM_WORDS = sha_loader_pkg::NUM_WORDS
) (
  input logic               CLK,
  input logic               RST,
  block_loader_160_if.slave bus
);
  import sha_loader_pkg::*;

  localparam int BLOCK_W = WORD_W * NUM_WORDS;

  load_state_t        state_reg, state_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [BLOCK_W-1:0] block_reg, block_next;
  logic               done_reg;

  logic [WORD_W-1:0]    word_packed;
  logic [NUM_WORDS-1:0] slot_sel;
  logic                 ready_c;
  logic                 write_c;
  logic                 accept_c;

`ifdef BLOCK_LOADER_BYTE_SWAP_EN
  word_byte_swap32 u_swap (
    .word_in  (bus.word_in),
    .word_out (word_packed)
  );
`else
  assign word_packed = bus.word_in;
`endif

  // One-hot slot decode: the current word count selects the destination slice.
  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_slot
    assign slot_sel[gi] = (count_reg == CNT_W'(gi));
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    block_next = block_reg;
    ready_c    = 1'b0;
    write_c    = 1'b0;
    accept_c   = 1'b0;

    case (state_reg)
      COLLECT: begin
        ready_c  = !bus.flush;
        accept_c = ready_c && bus.word_valid;
        if (accept_c) begin
          count_next = count_reg + 1'b1;
          if (count_reg == CNT_W'(NUM_WORDS - 1)) begin
            state_next = FULL;
          end
        end
      end
      FULL: begin
        // The block stays frozen here until the core releases the memory.
        write_c = !bus.core_busy && !bus.flush;
        if (write_c) begin
          state_next = COLLECT;
          count_next = '0;
        end
      end
      default: begin
        state_next = COLLECT;
        count_next = '0;
      end
    endcase

    for (int k = 0; k < NUM_WORDS; k++) begin
      if (accept_c && slot_sel[k]) begin
        block_next[BLOCK_W-1-k*WORD_W -: WORD_W] = word_packed;
      end
    end

    // Abort discards the partial or pending block but leaves the data bits alone.
    if (bus.flush) begin
      state_next = COLLECT;
      count_next = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= COLLECT;
      count_reg <= '0;
      block_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      block_reg <= block_next;
      done_reg  <= write_c;
    end
  end

  assign bus.word_ready = ready_c;
  assign bus.write_en   = write_c;
  assign bus.block_out  = block_reg;
  assign bus.word_count = count_reg;
  assign bus.block_done = done_reg;

endmodule

// File: tb/tb_block_loader_160.sv
// Scoreboard bench for block_loader_160: driver predicts per-cycle outputs and
// written blocks from a word-list model; a negedge monitor compares them.
module tb_block_loader_160;
  import sha_loader_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  block_loader_160_if bus ();

  block_loader_160 dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic               ready;
    logic               we;
    logic               done;
    logic [CNT_W-1:0]   cnt;
    logic [BLOCK_W-1:0] blk;
  } exp_t;

  exp_t               cyc_q[$];
  logic [BLOCK_W-1:0] blk_q[$];

  int errors = 0;
  int checks = 0;
  int writes = 0;

  // Reference model: list of slot contents plus "words held" and "block pending".
  int                m_cnt  = 0;
  bit                m_full = 1'b0;
  bit                m_done = 1'b0;
  logic [WORD_W-1:0] m_slot[NUM_WORDS];

  function automatic logic [WORD_W-1:0] stored_word(input logic [WORD_W-1:0] w);
`ifdef BLOCK_LOADER_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [BLOCK_W-1:0] model_block();
    logic [BLOCK_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      r = (r << WORD_W) | BLOCK_W'(m_slot[k]);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [BLOCK_W-1:0] act,
                     input logic [BLOCK_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic step(input logic rst, input logic fl, input logic v,
                      input logic [WORD_W-1:0] w, input logic busy);
    exp_t e;
    @(posedge CLK);
    #1;
    RST            = rst;
    bus.flush      = fl;
    bus.word_valid = v;
    bus.word_in    = w;
    bus.core_busy  = busy;

    e.ready = !m_full && !fl;
    e.we    = m_full && !busy && !fl;
    e.done  = m_done;
    e.cnt   = CNT_W'(m_cnt);
    e.blk   = model_block();
    cyc_q.push_back(e);
    if (e.we) blk_q.push_back(e.blk);

    if (rst) begin
      m_cnt  = 0;
      m_full = 1'b0;
      m_done = 1'b0;
      for (int k = 0; k < NUM_WORDS; k++) m_slot[k] = '0;
    end else begin
      m_done = e.we;
      if (fl) begin
        m_cnt  = 0;
        m_full = 1'b0;
      end else if (e.ready && v) begin
        m_slot[m_cnt] = stored_word(w);
        m_cnt++;
        if (m_cnt == NUM_WORDS) m_full = 1'b1;
      end else if (e.we) begin
        m_cnt  = 0;
        m_full = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n, input logic busy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, busy);
  endtask

  task automatic send(input int n, input logic [WORD_W-1:0] base, input logic busy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, base + WORD_W'(i), busy);
  endtask

  // Monitor: compares every predicted cycle, and every DUT write against the block queue.
  exp_t               mon_e;
  logic [BLOCK_W-1:0] mon_b;
  initial begin
    forever begin
      @(negedge CLK);
      if (cyc_q.size() > 0) begin
        mon_e = cyc_q.pop_front();
        chk("word_ready", BLOCK_W'(bus.word_ready), BLOCK_W'(mon_e.ready));
        chk("write_en",   BLOCK_W'(bus.write_en),   BLOCK_W'(mon_e.we));
        chk("block_done", BLOCK_W'(bus.block_done), BLOCK_W'(mon_e.done));
        chk("word_count", BLOCK_W'(bus.word_count), BLOCK_W'(mon_e.cnt));
        chk("block_out",  bus.block_out,            mon_e.blk);
      end
      if (bus.write_en === 1'b1) begin
        if (blk_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL write_block: write_en with no block expected, block_out=%h",
                   bus.block_out);
        end else begin
          mon_b = blk_q.pop_front();
          writes++;
          $display("write %0d block=%h", writes, bus.block_out);
          chk("write_block", bus.block_out, mon_b);
        end
      end
    end
  end

  initial begin
    logic fl, v, busy, rst;
    for (int k = 0; k < NUM_WORDS; k++) m_slot[k] = '0;
    bus.flush      = 1'b0;
    bus.word_valid = 1'b0;
    bus.word_in    = '0;
    bus.core_busy  = 1'b0;

    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(2, 1'b0);

    // Back-to-back load
    send(5, 32'hA000_0001, 1'b0);
    idle(3, 1'b0);

    // Core busy hold for 10 cycles, then release
    send(5, 32'hB000_0001, 1'b1);
    idle(10, 1'b1);
    idle(3, 1'b0);

    // Flush mid-block with a word offered, then a fresh block
    send(3, 32'hC000_0001, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    send(5, 32'hD000_0001, 1'b0);
    idle(2, 1'b0);

    // Flush while FULL and busy, then drop busy
    send(5, 32'hE000_0001, 1'b1);
    idle(2, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    idle(4, 1'b0);

    // Reset after two words
    send(2, 32'hF000_0001, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
    idle(2, 1'b0);

    // Byte order of word 0
    step(1'b0, 1'b0, 1'b1, 32'h1122_3344, 1'b0);
    send(4, 32'h5500_0001, 1'b0);
    idle(2, 1'b0);

    // Randomized traffic with bursty busy, rare flush and reset
    busy = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) busy = ~busy;
      v   = ($urandom_range(0, 9) < 7);
      fl  = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 249) == 0);
      step(rst, fl, v, $urandom, busy);
    end
    idle(4, 1'b0);
    @(posedge CLK);
    #1;

    chk("cycle_queue_drained", BLOCK_W'(cyc_q.size()), BLOCK_W'(0));
    chk("block_queue_drained", BLOCK_W'(blk_q.size()), BLOCK_W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
